// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART tx_data/tx_wr/tx_busy handshake; ports clk, reset, producer side wr_en/wr_data/full/empty/count, UART side tx_data/tx_wr/tx_busy, overflow (sticky only when UART_TX_FIFO_OVF_EN is defined)
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_busy,
  output logic                  overflow
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic wr_ok, pop;
  logic [CW-1:0] count_n;
  assign wr_ok = wr_en && !full;
  assign pop = state == LOAD;
  assign count_n = count + CW'(wr_ok) - CW'(pop);
  assign tx_wr = state == STROBE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = (!empty && !tx_busy) ? LOAD : IDLE;
      LOAD:      state_n = STROBE;
      STROBE:    state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_n = tx_busy ? WAIT_DONE : IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= state_n;
      count <= count_n;
      empty <= count_n == '0;
      full  <= count_n == CW'(DEPTH);
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end
`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    overflow <= reset ? 1'b0 : (overflow | (wr_en & full));
  end
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo with a queue reference model and a behavioural UART
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, tx_wr, overflow;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic tx_busy;
  logic uart_hold = 1'b0;
  int busy_left = 0;
  int busy_len = 0;
  logic got_wr = 1'b0;
  logic prev_wr = 1'b0;
  int n_tx = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
`ifdef UART_TX_FIFO_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .count(count), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_busy(tx_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign tx_busy = uart_hold | (busy_left != 0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
    if (exp_q.size() < 16) exp_q.push_back(b);
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_q.size() != 0 || busy_left != 0) && i < 3000) begin
      tick();
      i++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (3) tick();
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
  endtask

  // UART receiver side: every tx_wr pulse is checked against the oldest queued byte
  initial begin
    forever begin
      @(negedge clk);
      if (tx_wr) begin
        n_tx++;
        check("tx_while_busy", tx_busy, 0);
        check("tx_pulse_width", prev_wr, 0);
        if (exp_q.size() == 0) check("spurious_tx_wr", tx_wr, 0);
        else check("tx_data", tx_data, exp_q.pop_front());
      end
      got_wr = tx_wr;
      prev_wr = tx_wr;
    end
  end

  // UART busy timing: goes busy the cycle after a strobe, for a random or fixed length
  initial begin
    forever begin
      tick();
      if (got_wr) busy_left = (busy_len != 0) ? busy_len : int'($urandom_range(1, 6));
      else if (busy_left > 0) busy_left--;
    end
  end

  initial begin
    int saved;
    int i;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_data", tx_data, 8'h00);

    write(8'hA5);
    check("single_empty", empty, 0);
    check("single_count", count, 1);
    tick();
    check("single_no_early_wr", tx_wr, 0);
    tick();
    check("single_tx_wr", tx_wr, 1);
    check("single_tx_data", tx_data, 8'hA5);
    check("single_count_pop", count, 0);
    tick();
    check("single_wr_end", tx_wr, 0);
    drain();

    uart_hold = 1'b1;
    saved = n_tx;
    for (int k = 0; k < 16; k++) write(8'(k));
    check("burst_full", full, 1);
    check("burst_count", count, 16);
    write(8'hFF);
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, EXP_OVF);
    uart_hold = 1'b0;
    drain();
    check("burst_ntx", n_tx - saved, 16);
    check("ovf_sticky", overflow, EXP_OVF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_cleared", overflow, 0);

    uart_hold = 1'b1;
    for (int k = 0; k < 5; k++) write(8'(8'h30 + k));
    check("wp_pre_count", count, 5);
    uart_hold = 1'b0;
    tick();
    write(8'h5A);
    check("wp_count", count, 5);
    check("wp_full", full, 0);
    check("wp_empty", empty, 0);
    drain();

    uart_hold = 1'b1;
    busy_len = 10;
    for (int k = 0; k < 5; k++) write(8'(8'hC0 + k));
    uart_hold = 1'b0;
    saved = n_tx;
    i = 0;
    while (n_tx == saved && i < 100) begin
      tick();
      i++;
    end
    check("t6_tx_seen", n_tx - saved, 1);
    tick();
    check("t6_count_wait_done", count, 4);
    check("t6_busy", tx_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    busy_len = 0;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    saved = n_tx;
    repeat (40) tick();
    check("t6_no_tx", n_tx - saved, 0);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && exp_q.size() < 16) write(8'($urandom));
      else tick();
    end
    drain();
    check("rand_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
